traffic_light_seq: RTL and testbench

- Parametrised multi-approach traffic light sequencer.
- Drives NUM_APPROACH approaches round-robin through green, yellow and all-red phases, with tick-based phase timing and a flashing-yellow fault mode.
- Each approach has a 3-bit one-hot lamp vector {red,yellow,green} and a 2-bit legacy code: red=00, yellow=01, green=10, off=11.
- Sits between the tick prescaler and the lamp drivers of the toy track.

---
 rtl/traffic_light_seq.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_seq.sv
// Round-robin traffic light sequencer: GREEN -> YELLOW -> ALLRED per approach,
// tick-timed phases, and a flashing-yellow fault mode that overrides everything but reset.
module traffic_light_seq #(
  parameter int NUM_APPROACH = 2,
  parameter int TIMER_W      = 8,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  localparam int PW = (NUM_APPROACH > 1) ? $clog2(NUM_APPROACH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      tick,
  input  logic                      flash,
  output logic [3*NUM_APPROACH-1:0] lights,
  output logic [2*NUM_APPROACH-1:0] code,
  output logic [PW-1:0]             phase,
  output logic                      busy
);

  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TICKS - 1);
  localparam logic [PW-1:0]      LAST_PHASE  = PW'(NUM_APPROACH - 1);

  state_e                    state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic                      flash_on_q, flash_on_d;
  logic [3*NUM_APPROACH-1:0] lights_q, lights_d;
  logic [2*NUM_APPROACH-1:0] code_q, code_d;
  logic                      busy_q, busy_d;
  logic                      expired;

  function automatic logic [2:0] lamp_for(input state_e st, input logic [PW-1:0] ph,
                                          input logic fon, input logic [PW-1:0] idx);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    case (st)
      S_GREEN:  if (ph == idx) lamp = LAMP_GREEN;
      S_YELLOW: if (ph == idx) lamp = LAMP_YELLOW;
      S_FLASH:  lamp = fon ? LAMP_YELLOW : LAMP_OFF;
      default:  lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  function automatic logic [1:0] code_of(input logic [2:0] lamp);
    logic [1:0] c;
    case (lamp)
      LAMP_YELLOW: c = 2'b01;
      LAMP_GREEN:  c = 2'b10;
      LAMP_OFF:    c = 2'b11;
      default:     c = 2'b00;
    endcase
    return c;
  endfunction

  assign expired = tick && (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    phase_d    = phase_q;
    flash_on_d = flash_on_q;
    if (flash) begin
      // Fault mode wins over timer expiry and enable; flash_on restarts dark on entry.
      state_d = S_FLASH;
      timer_d = '0;
      if (state_q != S_FLASH) flash_on_d = 1'b0;
      else if (tick)          flash_on_d = ~flash_on_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (enable) begin
            state_d = S_GREEN;
            timer_d = GREEN_LOAD;
          end
        end
        S_GREEN: begin
          if (expired) begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LOAD;
          end else if (tick) timer_d = timer_q - TIMER_W'(1);
        end
        S_YELLOW: begin
          if (expired) begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LOAD;
          end else if (tick) timer_d = timer_q - TIMER_W'(1);
        end
        S_ALLRED: begin
          if (expired) begin
            if (enable) begin
              state_d = S_GREEN;
              timer_d = GREEN_LOAD;
              phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
            end else begin
              state_d = S_IDLE;
              timer_d = '0;
            end
          end else if (tick) timer_d = timer_q - TIMER_W'(1);
        end
        S_FLASH: begin
          state_d    = S_ALLRED;
          timer_d    = ALLRED_LOAD;
          flash_on_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they change on the same edge as the state.
  always_comb begin
    lights_d = '0;
    code_d   = '0;
    for (int a = 0; a < NUM_APPROACH; a++) begin
      lights_d[3*a +: 3] = lamp_for(state_d, phase_d, flash_on_d, PW'(a));
      code_d[2*a +: 2]   = code_of(lights_d[3*a +: 3]);
    end
    busy_d = (state_d == S_GREEN) || (state_d == S_YELLOW) || (state_d == S_ALLRED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      phase_q    <= '0;
      flash_on_q <= 1'b0;
      lights_q   <= {NUM_APPROACH{LAMP_RED}};
      code_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      flash_on_q <= flash_on_d;
      lights_q   <= lights_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
    end
  end

  assign lights = lights_q;
  assign code   = code_q;
  assign phase  = phase_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Bench for traffic_light_seq: a tick-counting behavioural model checked every cycle,
// plus literal lamp patterns for the directed scenarios.
module tb_traffic_light_seq;

  localparam int NA = 2;
  localparam int TW = 8;
  localparam int GT = 3;
  localparam int YT = 2;
  localparam int AT = 1;

  localparam logic [5:0] L_R    = 6'b100_100;
  localparam logic [5:0] L_G0   = 6'b100_001;
  localparam logic [5:0] L_Y0   = 6'b100_010;
  localparam logic [5:0] L_G1   = 6'b001_100;
  localparam logic [5:0] L_Y1   = 6'b010_100;
  localparam logic [5:0] L_DARK = 6'b000_000;
  localparam logic [5:0] L_FY   = 6'b010_010;
  localparam logic [3:0] C_R    = 4'b0000;
  localparam logic [3:0] C_G0   = 4'b0010;
  localparam logic [3:0] C_Y0   = 4'b0001;
  localparam logic [3:0] C_G1   = 4'b1000;
  localparam logic [3:0] C_Y1   = 4'b0100;
  localparam logic [3:0] C_DARK = 4'b1111;
  localparam logic [3:0] C_FY   = 4'b0101;

  localparam int M_IDLE = 0, M_GREEN = 1, M_YELLOW = 2, M_ALLRED = 3, M_FLASH = 4;

  logic          clk, rst, enable, tick, flash;
  logic [3*NA-1:0] lights;
  logic [2*NA-1:0] code;
  logic [0:0]      phase;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int m_mode    = M_IDLE;
  int m_grant   = 0;
  int m_elapsed = 0;
  bit m_fon     = 0;

  traffic_light_seq #(
    .NUM_APPROACH(NA), .TIMER_W(TW), .GREEN_TICKS(GT),
    .YELLOW_TICKS(YT), .ALLRED_TICKS(AT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .flash(flash),
    .lights(lights), .code(code), .phase(phase), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] lamp_code(input logic [2:0] lamp);
    case (lamp)
      3'b100:  return 2'b00;
      3'b010:  return 2'b01;
      3'b001:  return 2'b10;
      3'b000:  return 2'b11;
      default: return 2'bxx;
    endcase
  endfunction

  function automatic int duration(input int mode);
    case (mode)
      M_GREEN:  return GT;
      M_YELLOW: return YT;
      default:  return AT;
    endcase
  endfunction

  function automatic logic [3*NA-1:0] model_lights();
    logic [3*NA-1:0] l;
    for (int a = 0; a < NA; a++) begin
      if (m_mode == M_FLASH)                        l[3*a +: 3] = m_fon ? 3'b010 : 3'b000;
      else if (m_mode == M_GREEN  && a == m_grant)  l[3*a +: 3] = 3'b001;
      else if (m_mode == M_YELLOW && a == m_grant)  l[3*a +: 3] = 3'b010;
      else                                          l[3*a +: 3] = 3'b100;
    end
    return l;
  endfunction

  function automatic logic [2*NA-1:0] model_code();
    logic [3*NA-1:0] l;
    logic [2*NA-1:0] c;
    l = model_lights();
    for (int a = 0; a < NA; a++) c[2*a +: 2] = lamp_code(l[3*a +: 3]);
    return c;
  endfunction

  // Model: counts ticks spent in the current phase against that phase's duration.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_grant = 0; m_elapsed = 0; m_fon = 0;
    end else if (flash) begin
      if (m_mode != M_FLASH) begin
        m_mode = M_FLASH; m_fon = 0;
      end else if (tick) m_fon = !m_fon;
    end else if (m_mode == M_FLASH) begin
      m_mode = M_ALLRED; m_elapsed = 0;
    end else if (m_mode == M_IDLE) begin
      if (enable) begin m_mode = M_GREEN; m_elapsed = 0; end
    end else if (tick) begin
      if (m_elapsed + 1 == duration(m_mode)) begin
        m_elapsed = 0;
        if (m_mode == M_GREEN)       m_mode = M_YELLOW;
        else if (m_mode == M_YELLOW) m_mode = M_ALLRED;
        else if (enable) begin
          m_mode  = M_GREEN;
          m_grant = (m_grant + 1) % NA;
        end else m_mode = M_IDLE;
      end else m_elapsed++;
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [5:0] l, input logic [3:0] c,
                           input int ph, input bit b);
    check({name, "_lights"}, 16'(lights), 16'(l));
    check({name, "_code"},   16'(code),   16'(c));
    check({name, "_phase"},  16'(phase),  16'(ph));
    check({name, "_busy"},   16'(busy),   16'(b));
  endtask

  task automatic wait_lights(input string name, input logic [5:0] l, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (lights == l) seen = 1;
    end
    check({name, "_reached"}, 16'(seen), 16'd1);
  endtask

  task automatic check_invariants();
    bit ok = 1;
    int nonred = 0;
    logic [2:0] lamp;
    for (int a = 0; a < NA; a++) begin
      lamp = lights[3*a +: 3];
      if (!(lamp inside {3'b000, 3'b001, 3'b010, 3'b100})) ok = 0;
      if (code[2*a +: 2] !== lamp_code(lamp)) ok = 0;
      if (lamp != 3'b100) nonred++;
    end
    if (nonred > 1 && lights != L_FY && lights != L_DARK) ok = 0;
    check("invariant", 16'(ok), 16'd1);
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_lights", 16'(lights), 16'(model_lights()));
      check("model_code",   16'(code),   16'(model_code()));
      check("model_phase",  16'(phase),  16'(m_grant));
      check("model_busy",   16'(busy),
            16'(m_mode == M_GREEN || m_mode == M_YELLOW || m_mode == M_ALLRED));
      check_invariants();
    end
  end

  // directed stimulus
  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; flash = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("reset", L_R, C_R, 0, 0);
    rst = 1'b0; chk_en = 1;
    @(negedge clk);
    check_lit("idle_hold", L_R, C_R, 0, 0);

    // Full cycle with tick every clock: 3 green, 2 yellow, 1 all-red.
    enable = 1'b1; tick = 1'b1;
    @(negedge clk);            check_lit("g0_first", L_G0, C_G0, 0, 1);
    repeat (3) @(negedge clk); check_lit("y0", L_Y0, C_Y0, 0, 1);
    repeat (2) @(negedge clk); check_lit("allred0", L_R, C_R, 0, 1);
    @(negedge clk);            check_lit("g1", L_G1, C_G1, 1, 1);
    repeat (6) @(negedge clk); check_lit("g0_wrap", L_G0, C_G0, 0, 1);
    repeat (6) @(negedge clk); check_lit("g1_again", L_G1, C_G1, 1, 1);

    // Tick every 4th cycle: green holds for 12 clocks.
    for (int i = 0; i < 12; i++) begin
      check_lit("slow_green", L_G1, C_G1, 1, 1);
      tick = (i % 4 == 3);
      @(negedge clk);
    end
    check_lit("slow_yellow", L_Y1, C_Y1, 1, 1);

    // Enable dropped during approach 1 green: cycle completes, then IDLE.
    tick = 1'b1;
    wait_lights("to_g1", L_G1, 20);
    enable = 1'b0;
    wait_lights("drop_yellow", L_Y1, 5);
    wait_lights("drop_allred", L_R, 5);
    check("drop_allred_busy", 16'(busy), 16'd1);
    @(negedge clk);            check_lit("idle_after_drop", L_R, C_R, 1, 0);
    repeat (3) @(negedge clk); check_lit("idle_stays", L_R, C_R, 1, 0);

    // Flash during yellow, then release.
    enable = 1'b1;
    wait_lights("to_y1", L_Y1, 10);
    flash = 1'b1;
    @(negedge clk); check_lit("flash_dark0", L_DARK, C_DARK, 1, 0);
    @(negedge clk); check_lit("flash_yel0",  L_FY,   C_FY,   1, 0);
    @(negedge clk); check_lit("flash_dark1", L_DARK, C_DARK, 1, 0);
    @(negedge clk); check_lit("flash_yel1",  L_FY,   C_FY,   1, 0);
    flash = 1'b0;
    @(negedge clk); check_lit("post_flash_allred", L_R, C_R, 1, 1);
    @(negedge clk); check_lit("post_flash_green", L_G0, C_G0, 0, 1);

    // Asynchronous reset mid-green, checked between clock edges.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_lit("async_reset", L_R, C_R, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Mixed stimulus under the per-cycle model and invariant checks.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      enable = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      tick   = ($urandom_range(0, 2) != 0);
      if (flash) flash = ($urandom_range(0, 3) != 0);
      else       flash = (i < 300) && ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
